regfile_operand_fetch: RTL

- Initiator-side access sequencer for a register bank held in a single-port, synchronous-read RAM (BRAM-style, 1-cycle read latency).
- Serves operand-fetch requests (rs1, rs2) from the core over a valid/ready handshake and returns both operands on a response handshake.
- Arbitrates core writeback into the same port; writeback always wins.
- x0 reads as zero and is never written.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_operand_slot.sv | 93 +++++++++
 rtl/regfile_operand_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-bank operand fetch sequencer.
// Optional writeback forwarding into fetched operands: REGFILE_WB_FORWARD_EN.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        ISSUE2,
        DRAIN,
        RESP
    } fetch_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RS1,
        OP_RS2
    } op_sel_t;

    // One in-flight read: which operand it belongs to, and whether it is an
    // x0 slot that must resolve to zero instead of RAM data.
    typedef struct packed {
        op_sel_t op;
        logic    zero;
    } pend_t;

    localparam pend_t PEND_IDLE = '{op: OP_NONE, zero: 1'b0};

endpackage

// File: rtl/regfile_operand_slot.sv
// One fetched operand register: RAM capture, x0 zero-forcing and, when
// REGFILE_WB_FORWARD_EN is defined, writeback forwarding into the operand.
module regfile_operand_slot
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
)
(
    input  logic            clk,
    input  logic            srst,
    input  logic [AW-1:0]   rs,
    input  logic            issue,
    input  logic            clr,
    input  logic            cap_en,
    input  logic            cap_zero,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] operand_d;

`ifdef REGFILE_WB_FORWARD_EN
    logic live_q;
    logic live_d;
    logic fwd_q;
    logic fwd_d;
    logic fwd_hit;

    // live: the read has left the port, so the RAM can no longer supply a
    // later write. fwd: a forwarded value already supersedes the pending data.
    always_comb begin
        fwd_hit   = wb_valid && (wb_addr != '0) && (wb_addr == rs) && live_q;
        operand_d = operand_q;
        live_d    = live_q;
        fwd_d     = fwd_q;
        if (issue) begin
            live_d = 1'b1;
            fwd_d  = 1'b0;
        end
        if (clr) begin
            live_d = 1'b0;
            fwd_d  = 1'b0;
        end
        if (cap_en && !fwd_q) begin
            operand_d = cap_zero ? '0 : mem_rdata;
        end
        if (fwd_hit) begin
            operand_d = wb_data;
            fwd_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            operand_q <= '0;
            live_q    <= 1'b0;
            fwd_q     <= 1'b0;
        end else begin
            operand_q <= operand_d;
            live_q    <= live_d;
            fwd_q     <= fwd_d;
        end
    end
`else
    logic unused_fwd_inputs;

    // Without forwarding the operand is frozen once captured.
    always_comb begin
        operand_d = operand_q;
        if (cap_en) begin
            operand_d = cap_zero ? '0 : mem_rdata;
        end
    end

    assign unused_fwd_inputs = ^{rs, issue, clr, wb_valid, wb_addr, wb_data};

    always_ff @(posedge clk) begin
        if (srst) begin
            operand_q <= '0;
        end else begin
            operand_q <= operand_d;
        end
    end
`endif

    assign operand = operand_q;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch sequencer for a single-port synchronous-read register RAM;
// writeback always owns the port. Forwarding option: REGFILE_WB_FORWARD_EN.
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rd1,
    output logic [XLEN-1:0] rsp_rd2,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    fetch_state_t    state_q, state_d;
    logic [AW-1:0]   rs1_q, rs1_d;
    logic [AW-1:0]   rs2_q, rs2_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            wb_ready_q, wb_ready_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    pend_t           pend_iss_q, pend_iss_d;
    pend_t           pend_cap_q, pend_cap_d;

    logic            wb_write;
    logic            accept;
    logic            rsp_fire;

    logic [1:0]      slot_issue;
    logic [1:0]      slot_cap;
    logic [AW-1:0]   slot_rs  [2];
    logic [XLEN-1:0] slot_op  [2];

    always_comb begin
        wb_write    = wb_valid && (wb_addr != '0);
        accept      = (state_q == IDLE) && req_ready_q && req_valid;
        rsp_fire    = (state_q == RESP) && rsp_valid_q && rsp_ready;

        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        pend_iss_d  = PEND_IDLE;
        // A read on the port this cycle returns data next cycle.
        pend_cap_d  = pend_iss_q;

        if (wb_write) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_addr;
            mem_wdata_d = wb_data;
        end

        // x0 reads never touch the port, so they advance even under a
        // writeback; real reads wait for a free port.
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = ISSUE1;
                end
            end
            ISSUE1: begin
                if (rs1_q == '0) begin
                    pend_iss_d = '{op: OP_RS1, zero: 1'b1};
                    state_d    = ISSUE2;
                end else if (!wb_write) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = rs1_q;
                    pend_iss_d = '{op: OP_RS1, zero: 1'b0};
                    state_d    = ISSUE2;
                end
            end
            ISSUE2: begin
                if (rs2_q == '0) begin
                    pend_iss_d = '{op: OP_RS2, zero: 1'b1};
                    state_d    = DRAIN;
                end else if (!wb_write) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = rs2_q;
                    pend_iss_d = '{op: OP_RS2, zero: 1'b0};
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The last read's data is captured on this edge.
                if (pend_iss_q.op == OP_NONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        wb_ready_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wb_ready_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pend_iss_q  <= PEND_IDLE;
            pend_cap_q  <= PEND_IDLE;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wb_ready_q  <= wb_ready_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pend_iss_q  <= pend_iss_d;
            pend_cap_q  <= pend_cap_d;
        end
    end

    assign slot_rs[0]    = rs1_q;
    assign slot_rs[1]    = rs2_q;
    assign slot_issue[0] = (pend_iss_d.op == OP_RS1);
    assign slot_issue[1] = (pend_iss_d.op == OP_RS2);
    assign slot_cap[0]   = (pend_cap_q.op == OP_RS1);
    assign slot_cap[1]   = (pend_cap_q.op == OP_RS2);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            regfile_operand_slot #(
                .XLEN (XLEN),
                .AW   (AW)
            ) u_slot (
                .clk       (clk),
                .srst      (reset),
                .rs        (slot_rs[gi]),
                .issue     (slot_issue[gi]),
                .clr       (rsp_fire),
                .cap_en    (slot_cap[gi]),
                .cap_zero  (pend_cap_q.zero),
                .mem_rdata (mem_rdata),
                .wb_valid  (wb_valid),
                .wb_addr   (wb_addr),
                .wb_data   (wb_data),
                .operand   (slot_op[gi])
            );
        end
    endgenerate

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign wb_ready  = wb_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_rd1   = slot_op[0];
    assign rsp_rd2   = slot_op[1];

endmodule
